// File: rtl/fetch_refill_controller_pkg.sv
// Shared types and sizing for the instruction-line refill controller.
package fetch_refill_controller_pkg;

  localparam int unsigned LineWords = 4;
  localparam int unsigned IdxWidth  = 2;
  localparam int unsigned OffWidth  = 2;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StDeliver = 2'd2,
    StSettle  = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_refill_controller_line_assembler.sv
// Line buffer for a refill: places returned words by index and counts completed words.
module refill_line_assembler
  import fetch_refill_controller_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned LINE_WORDS = LineWords,
  localparam int unsigned IdxW      = $clog2(LINE_WORDS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [IdxW-1:0]                start_idx,
  input  logic                           wr_en,
  input  logic [WORD_WIDTH-1:0]          wr_data,
  output logic [WORD_WIDTH*LINE_WORDS-1:0] line_out,
  output logic [IdxW-1:0]                word_idx,
  output logic                           done
);

  localparam logic [IdxW:0] FullCount = (IdxW + 1)'(LINE_WORDS);

  logic [WORD_WIDTH*LINE_WORDS-1:0] line_q;
  logic [IdxW-1:0]                  idx_q;
  logic [IdxW:0]                    cnt_q;
  logic [LINE_WORDS-1:0]            word_we;

  always_comb begin
    word_we = '0;
    for (int i = 0; i < int'(LINE_WORDS); i++) begin
      word_we[i] = wr_en && (idx_q == i[IdxW-1:0]);
    end
  end

  // The buffer is deliberately not cleared on start: it keeps the previous line.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      for (int i = 0; i < int'(LINE_WORDS); i++) begin
        if (word_we[i]) begin
          line_q[i*WORD_WIDTH +: WORD_WIDTH] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      idx_q <= start_idx;
      cnt_q <= '0;
    end else if (wr_en) begin
      idx_q <= idx_q + 1'b1;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign line_out = line_q;
  assign word_idx = idx_q;
  assign done     = (cnt_q == FullCount);

endmodule

// File: rtl/fetch_refill_controller.sv
// Refills a missing instruction line from word-wide main memory and strobes it to fetch.
// Optional macro REFILL_CRITICAL_WORD_FIRST_EN: start at the missed word and wrap.
module fetch_refill_controller
  import fetch_refill_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned LINE_WORDS = LineWords
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             hit,
  input  logic [ADDR_WIDTH-1:0]            pc,
  output logic                             mem_req,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic                             mem_ack,
  input  logic [WORD_WIDTH-1:0]            mem_rdata,
  output logic [WORD_WIDTH*LINE_WORDS-1:0] line_out,
  output logic                             line_valid,
  output logic                             busy
);

  localparam int unsigned IdxW  = $clog2(LINE_WORDS);
  localparam int unsigned OffW  = OffWidth;
  localparam int unsigned BaseW = ADDR_WIDTH - IdxW - OffW;

  state_e           state_q, state_d;
  logic [BaseW-1:0] base_q;
  logic [IdxW-1:0]  start_idx;
  logic [IdxW-1:0]  word_idx;
  logic             start;
  logic             accept;
  logic             done;
  logic             unused_pc_bits;

  assign start  = (state_q == StIdle) && !hit;
  assign accept = mem_req && mem_ack;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  assign start_idx      = pc[OffW +: IdxW];
  assign unused_pc_bits = ^pc[OffW-1:0];
`else
  assign start_idx      = '0;
  assign unused_pc_bits = ^pc[OffW+IdxW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
    end else if (start) begin
      base_q <= pc[ADDR_WIDTH-1 -: BaseW];
    end
  end

  refill_line_assembler #(
    .WORD_WIDTH (WORD_WIDTH),
    .LINE_WORDS (LINE_WORDS)
  ) u_assembler (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_idx (start_idx),
    .wr_en     (accept),
    .wr_data   (mem_rdata),
    .line_out  (line_out),
    .word_idx  (word_idx),
    .done      (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // SETTLE always returns to IDLE: hit is stale while the line is being written.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (!hit) state_d = StIssue;
      StIssue:   if (done) state_d = StDeliver;
      StDeliver: state_d = StSettle;
      StSettle:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // The done cycle keeps mem_req low so no fifth request is ever presented.
  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = '0;
    line_valid = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StIssue: begin
        mem_req  = !done;
        mem_addr = {base_q, word_idx, {OffW{1'b0}}};
      end
      StDeliver: line_valid = 1'b1;
      StSettle:  ;
      default:   busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fetch_refill_controller.sv
// Scoreboard bench: stimulus queues expected addresses and lines, monitors pop and compare.
module tb_fetch_refill_controller;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int LW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           hit;
  logic [AW-1:0]  pc;
  logic           mem_req;
  logic [AW-1:0]  mem_addr;
  logic           mem_ack;
  logic [WW-1:0]  mem_rdata;
  logic [WW*LW-1:0] line_out;
  logic           line_valid;
  logic           busy;

  always #5 clk = ~clk;

  fetch_refill_controller #(
    .ADDR_WIDTH (AW),
    .WORD_WIDTH (WW),
    .LINE_WORDS (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hit        (hit),
    .pc         (pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .line_out   (line_out),
    .line_valid (line_valid),
    .busy       (busy)
  );

  typedef struct {
    logic [127:0] line;
    int           at;
  } line_exp_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ack_cnt = 0;
  int          delay = 0;
  int          wait_cnt = 0;
  bit          resp_en = 1'b0;
  bit          stray_en = 1'b0;
  bit          stray_once = 1'b0;
  bit          lv_prev = 1'b0;
  logic [31:0] data_base = 32'h0;
  logic [31:0] addr_q[$];
  line_exp_t   line_q[$];

  localparam logic [127:0] LineA = 128'h000000A3_000000A2_000000A1_000000A0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: ack delay words after each request; data derives from the word index.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (stray_en) begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end else if (stray_once) begin
        mem_ack    = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        stray_once = 1'b0;
      end else if (resp_en && mem_req) begin
        if (wait_cnt >= delay) begin
          mem_ack   = 1'b1;
          mem_rdata = data_base + 32'(mem_addr[3:2]);
          if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_addr: unexpected request got %0h expected none", mem_addr);
          end else begin
            check("mem_addr", 128'(mem_addr), 128'(addr_q.pop_front()));
          end
          ack_cnt++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    line_exp_t e;
    forever begin
      @(negedge clk);
      if (line_valid) begin
        check("line_valid_width", 128'(lv_prev), 128'(0));
        if (line_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL line_valid: got unexpected strobe expected none (cycle %0d)", cyc);
        end else begin
          e = line_q.pop_front();
          check("line_out", line_out, e.line);
          check("line_valid_cycle", 128'(cyc + 1), 128'(e.at));
        end
      end
      lv_prev = line_valid;
    end
  end

  // Called at a negedge; the miss is sampled at the following posedge.
  task automatic start_refill(input logic [31:0] addr, input int d, input logic [31:0] base,
                              input logic [127:0] exp_line, input int lat);
    line_exp_t e;
    delay     = d;
    data_base = base;
    resp_en   = 1'b1;
    e.line    = exp_line;
    e.at      = cyc + 1 + lat;
    line_q.push_back(e);
    pc  = addr;
    hit = 1'b0;
    @(negedge clk);
    hit = 1'b1;
  endtask

  task automatic push_addrs(input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] a2, input logic [31:0] a3);
    addr_q.push_back(a0);
    addr_q.push_back(a1);
    addr_q.push_back(a2);
    addr_q.push_back(a3);
  endtask

  task automatic wait_line(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (line_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: got no line_valid expected strobe within 200 cycles", name);
    end
  endtask

  task automatic wait_acks(input int target, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ack_cnt >= target) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d acks expected %0d", name, ack_cnt, target);
    end
  endtask

  task automatic check_settle_idle(input string name);
    @(negedge clk);
    check({name, "_busy_settle"}, 128'(busy), 128'(1));
    @(negedge clk);
    check({name, "_busy_idle"}, 128'(busy), 128'(0));
  endtask

  initial begin
    int s;
    rst = 1'b1;
    hit = 1'b1;
    pc  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_line_out", line_out, 128'(0));
    check("rst_line_valid", 128'(line_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Sequential refill, two-cycle ack delay.
    push_addrs(32'h40, 32'h44, 32'h48, 32'h4C);
    start_refill(32'h40, 2, 32'hA0, LineA, 14);
    wait_line("t1_line");
    check_settle_idle("t1");

    // Hits with stray acks: nothing may move.
    resp_en  = 1'b0;
    stray_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("hit_mem_req", 128'(mem_req), 128'(0));
      check("hit_line_valid", 128'(line_valid), 128'(0));
      check("hit_busy", 128'(busy), 128'(0));
      check("hit_line_out", line_out, LineA);
    end
    stray_en = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Zero-wait memory.
    push_addrs(32'h100, 32'h104, 32'h108, 32'h10C);
    start_refill(32'h100, 0, 32'h10, 128'h00000013_00000012_00000011_00000010, 6);
    wait_line("t3_line");
    check_settle_idle("t3");

    // Reset after two words of a refill.
    addr_q.push_back(32'h80);
    addr_q.push_back(32'h84);
    delay     = 1;
    data_base = 32'h20;
    resp_en   = 1'b1;
    s   = ack_cnt;
    pc  = 32'h80;
    hit = 1'b0;
    @(negedge clk);
    hit = 1'b1;
    wait_acks(s + 2, "t4_acks");
    resp_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4_mem_req", 128'(mem_req), 128'(0));
    check("t4_busy", 128'(busy), 128'(0));
    check("t4_line_out", line_out, 128'(0));
    rst        = 1'b0;
    stray_once = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_stray_line_out", line_out, 128'(0));
    check("t4_stray_busy", 128'(busy), 128'(0));
    check("t4_addr_q_drained", 128'(addr_q.size()), 128'(0));
    push_addrs(32'h80, 32'h84, 32'h88, 32'h8C);
    start_refill(32'h80, 0, 32'h30, 128'h00000033_00000032_00000031_00000030, 6);
    wait_line("t4_line");
    check_settle_idle("t4");

    // Branch redirect mid-refill, then a genuine miss on the new line.
    push_addrs(32'h40, 32'h44, 32'h48, 32'h4C);
    s = ack_cnt;
    start_refill(32'h40, 1, 32'hB0, 128'h000000B3_000000B2_000000B1_000000B0, 10);
    wait_acks(s + 2, "t5_acks");
    pc  = 32'h200;
    hit = 1'b0;
    wait_line("t5_line");
    @(negedge clk);
    check("t5_busy_settle", 128'(busy), 128'(1));
    begin
      line_exp_t e;
      data_base = 32'hC0;
      push_addrs(32'h200, 32'h204, 32'h208, 32'h20C);
      e.line = 128'h000000C3_000000C2_000000C1_000000C0;
      e.at   = cyc + 2 + 10;
      line_q.push_back(e);
    end
    @(negedge clk);
    check("t5_idle_mem_req", 128'(mem_req), 128'(0));
    check("t5_idle_busy", 128'(busy), 128'(0));
    @(negedge clk);
    hit = 1'b1;
    check("t5_new_mem_req", 128'(mem_req), 128'(1));
    wait_line("t5_line2");
    check_settle_idle("t5b");

    // Miss at 0x48: order depends on critical-word-first build.
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    push_addrs(32'h48, 32'h4C, 32'h40, 32'h44);
`else
    push_addrs(32'h40, 32'h44, 32'h48, 32'h4C);
`endif
    start_refill(32'h48, 0, 32'hD0, 128'h000000D3_000000D2_000000D1_000000D0, 6);
    wait_line("t6_line");
    check_settle_idle("t6");

    repeat (3) @(negedge clk);
    check("addr_q_empty", 128'(addr_q.size()), 128'(0));
    check("line_q_empty", 128'(line_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_refill_controller.md
Name: fetch_refill_controller

Overview:
- Sits directly upstream of the fetch stage's instruction memory.
- Detects an instruction-memory miss (hit low) for the current PC and fetches the missing 128-bit line from word-wide main memory, one 32-bit word per handshake.
- Assembles the four words and presents the full line on line_out, which drives the fetch stage's mem_in, with a one-cycle line_valid strobe.
- Fetch stalls naturally on hit low until the line is written.

Parameters:
- ADDR_WIDTH, 32, byte-address width of pc and mem_addr.
- WORD_WIDTH, 32, main-memory data width.
- LINE_WORDS, 4, words per line; line_out width = WORD_WIDTH*LINE_WORDS (128). Must be a power of 2.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- hit  input  1  instruction-memory hit for pc; low = miss.
- pc  input  ADDR_WIDTH  address currently being fetched.
- mem_req  output  1  level request to main memory; held until mem_ack.
- mem_addr  output  ADDR_WIDTH  word-aligned address of the requested word.
- mem_ack  input  1  one-cycle pulse: mem_rdata valid for the current request.
- mem_rdata  input  WORD_WIDTH  returned word.
- line_out  output  WORD_WIDTH*LINE_WORDS  assembled line, connects to the fetch stage's mem_in.
- line_valid  output  1  one-cycle strobe: line_out is complete and must be written.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at clk edge), from any state:
  - state goes to IDLE; mem_req=0, mem_addr=0, line_out=0, line_valid=0, busy=0.
  - An in-flight refill is abandoned; a later mem_ack is ignored.
- States: IDLE, ISSUE, DELIVER, SETTLE.
- IDLE:
  - If hit=0, latch base = pc[ADDR_WIDTH-1:4] and start word index w=0, then go to ISSUE.
  - mem_req rises one cycle after the miss is sampled.
- ISSUE:
  - mem_req=1, mem_addr = {base, w, 2'b00}.
  - On mem_ack, write mem_rdata into line_out[32w+31:32w], then increment w modulo LINE_WORDS.
  - mem_req stays high across consecutive words; back-to-back acks give one word per cycle.
  - After the LINE_WORDS-th ack, drop mem_req in the next cycle and go to DELIVER.
  - Maximum of one outstanding request.
- DELIVER: line_valid=1 for exactly one cycle, line_out stable, then go to SETTLE.
- SETTLE:
  - One cycle in which hit is ignored, because the memory writes the line at this edge and hit is still stale. Then go to IDLE.
  - A genuine new miss, e.g. after a branch to another line, is detected in IDLE.
- line_out holds its last value outside ISSUE; it is not cleared between refills.
- mem_ack while not in ISSUE is ignored.
- pc changing during a refill (branch redirect) does not abort it. The latched base is used, and the line is still delivered.
- Latency with ack delay d cycles per word: line_valid is asserted 1 + LINE_WORDS*(d+1) + 1 cycles after the miss is sampled.
- Word index and address arithmetic are unsigned and wrap modulo LINE_WORDS within the line; the line base never changes during a refill.

Optional Feature:
- Macro: REFILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Starting index w = pc[3:2]; words are requested in wrap order (e.g. miss at 0x48 gives 0x48, 0x4C, 0x40, 0x44).
  - Placement in line_out remains address-indexed.
  - Completion is still after LINE_WORDS acks.
- Undefined: w always starts at 0, giving sequential order.

Decomposition:
- Shared package:
  - state enum/encoding (IDLE=2'd0, ISSUE=2'd1, DELIVER=2'd2, SETTLE=2'd3).
  - LINE_WORDS, the word-index width (log2 LINE_WORDS = 2), and the byte-offset width (2).
- One natural sub-module: refill_line_assembler. It holds line_out and the word counter, and provides a write-enable-by-index plus a done flag. The FSM stays in the top.

Test Plan:
- Miss at pc=0x0000_0040, memory acks 2 cycles after each request with data 0xA0..0xA3:
  - mem_addr sequence 0x40, 0x44, 0x48, 0x4C.
  - line_out = {A3, A2, A1, A0}, with A0 in bits [31:0].
  - one line_valid pulse; busy low 2 cycles after line_valid.
- hit held 1 for 50 cycles with random mem_ack pulses -> mem_req, line_valid and busy stay 0; line_out unchanged.
- Zero-wait memory (mem_ack in the same cycle as mem_req) on a miss at 0x100 -> 4 consecutive acks; line_valid 6 cycles after the miss is sampled.
- rst asserted after 2 of 4 words of a refill -> next cycle mem_req=0, busy=0, line_out=0. A following stray mem_ack does not change line_out. A fresh miss restarts at word 0.
- pc redirected to 0x200 mid-refill of line 0x40 -> remaining addresses stay 0x48, 0x4C; the line is delivered. After SETTLE, with hit=0, a new refill starts at 0x200.
- With REFILL_CRITICAL_WORD_FIRST_EN, miss at pc=0x48 -> requests 0x48, 0x4C, 0x40, 0x44; words land at indices 2, 3, 0, 1 of line_out.
